// File: rtl/float_to_pcm.sv
// rtl/float_to_pcm.sv - floating-point sample to saturated signed PCM with warm-up discard and output FIFO
//
// Ports:
//   clk        single clock
//   rst        synchronous active-high reset
//   in         sample {sign, exp[EXP_W], mant[MANT_W]}, exponent bias 2^(EXP_W-1)-1
//   in_valid   new sample this cycle
//   out_data   PCM word at the FIFO head (0 while empty)
//   out_valid  FIFO not empty
//   out_ready  consumer accepts out_data
//   sat        pulse: sample in stage 2 was clipped
//   drop       pulse: converted sample lost to a full FIFO
//   level      FIFO occupancy
// Build option: FLOAT_PCM_ROUND_EN selects round-half-away-from-zero on right shifts
// (truncation otherwise).

module float_to_pcm #(
    parameter int OUT_W      = 16,
    parameter int FRAC_W     = 15,
    parameter int WARMUP     = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [EXP_W+MANT_W:0]         in,
    input  logic                          in_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat,
    output logic                          drop,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int SIG_W = MANT_W + 1;
    localparam int SH_W  = $clog2(2**EXP_W + OUT_W + FRAC_W + MANT_W) + 2;
    // Wide enough for any left shift that is not already known to overflow.
    localparam int MW    = SIG_W + OUT_W + 1;
    localparam int WC_W  = $clog2(WARMUP + 2);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [MW-1:0] POS_MAX = MW'(2**(OUT_W-1) - 1);
    localparam logic [MW-1:0] NEG_MAG = MW'(2**(OUT_W-1));

    // ---------------- warm-up discard ----------------
    logic [WC_W-1:0] warm_cnt;
    logic            warm_done;
    logic            accept;

    assign warm_done = (warm_cnt == WC_W'(WARMUP));
    assign accept    = in_valid && warm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (in_valid && !warm_done) begin
            warm_cnt <= warm_cnt + WC_W'(1);
        end
    end

    // ---------------- stage 1: unpack ----------------
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MANT_W-1:0]      in_mant;
    logic signed [SH_W-1:0] in_sh;

    assign {in_sign, in_exp, in_mant} = in;
    assign in_sh = $signed(SH_W'(in_exp)) - SH_W'(BIAS - FRAC_W + MANT_W);

    logic                   s1_valid;
    logic                   s1_sign;
    logic [SIG_W-1:0]       s1_sig;
    logic signed [SH_W-1:0] s1_sh;
    logic                   s1_inf;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sig   <= '0;
            s1_sh    <= '0;
            s1_inf   <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_sign  <= in_sign;
            s1_sig   <= (in_exp == '0) ? '0 : {1'b1, in_mant};
            s1_sh    <= in_sh;
            s1_inf   <= &in_exp;
        end
    end

    // ---------------- stage 2: shift, sign, saturate ----------------
    logic [MW-1:0]    mag;
    logic             ovf;
    logic [SH_W-1:0]  rsh;

    always_comb begin
        mag = '0;
        ovf = 1'b0;
        rsh = '0;
        if (s1_inf) begin
            ovf = 1'b1;
        end else if (!s1_sh[SH_W-1]) begin
            // A leading one shifted to bit OUT_W or beyond can never fit.
            if (s1_sh >= SH_W'(OUT_W)) begin
                ovf = (s1_sig != '0);
            end else begin
                mag = MW'(s1_sig) << s1_sh;
            end
        end else begin
            rsh = -s1_sh;
`ifdef FLOAT_PCM_ROUND_EN
            mag = (MW'(s1_sig) + (MW'(1) << (rsh - SH_W'(1)))) >> rsh;
`else
            mag = MW'(s1_sig) >> rsh;
`endif
        end
    end

    logic [OUT_W-1:0] s2_next;
    logic             sat_next;

    always_comb begin
        s2_next  = '0;
        sat_next = 1'b0;
        if (!s1_sign) begin
            if (ovf || mag > POS_MAX) begin
                s2_next  = {1'b0, {(OUT_W-1){1'b1}}};
                sat_next = 1'b1;
            end else begin
                s2_next = mag[OUT_W-1:0];
            end
        end else begin
            // Magnitude exactly 2^(OUT_W-1) is representable when negative.
            if (ovf || mag > NEG_MAG) begin
                s2_next  = {1'b1, {(OUT_W-1){1'b0}}};
                sat_next = 1'b1;
            end else begin
                s2_next = '0 - mag[OUT_W-1:0];
            end
        end
    end

    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic             s2_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_data  <= s2_next;
            s2_sat   <= sat_next;
        end
    end

    assign sat = s2_valid && s2_sat;

    // ---------------- output FIFO ----------------
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = out_valid && out_ready;
    // A pop frees the head slot in the same edge, so a push at full still fits.
    assign push  = s2_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            drop_q <= s2_valid && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr[AW-1:0]] <= s2_data;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign drop      = drop_q;
    assign level     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_float_to_pcm.sv
// tb/tb_float_to_pcm.sv - self-checking bench for float_to_pcm

module tb_float_to_pcm;

    localparam int OUT_W  = 16;
    localparam int FRAC_W = 15;
    localparam int WARMUP = 4;
    localparam int DEPTH  = 8;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat;
    logic        drop;
    logic [3:0]  level;

    always #5 clk = ~clk;

    float_to_pcm #(
        .OUT_W(OUT_W), .FRAC_W(FRAC_W), .WARMUP(WARMUP),
        .FIFO_DEPTH(DEPTH), .EXP_W(EXP_W), .MANT_W(MANT_W)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat(sat), .drop(drop), .level(level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: FIFO contents, two in-flight pipeline slots, warm-up count
    int mq[$];
    int got[$];
    bit hv[2];
    int hd[2];
    bit hs[2];
    int wcnt;
    bit exp_sat;
    bit exp_drop;
    int drop_cnt;

    task automatic check(input string tag, input int got_v, input int exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    // value = (-1)^s * 1.mant * 2^(e-127), scaled by 2^15, rounded/truncated, clipped
    function automatic void ref_conv(input logic [31:0] f, output int d, output bit s);
        bit  sg;
        int  e;
        int  m;
        real mg;
        real q;
        sg = f[31];
        e  = int'(f[30:23]);
        m  = int'(f[22:0]);
        d  = 0;
        s  = 1'b0;
        if (e == 255) begin
            d = sg ? -32768 : 32767;
            s = 1'b1;
        end else if (e != 0) begin
            mg = real'(8388608 + m) * (2.0 ** real'(e - 127 + FRAC_W - MANT_W));
`ifdef FLOAT_PCM_ROUND_EN
            q = $floor(mg + 0.5);
`else
            q = $floor(mg);
`endif
            if (!sg) begin
                if (q > 32767.0) begin d = 32767; s = 1'b1; end
                else d = $rtoi(q);
            end else begin
                if (q > 32768.0) begin d = -32768; s = 1'b1; end
                else d = -$rtoi(q);
            end
        end
    endfunction

    // encode k * 2^-15 (k nonzero integer) as a float
    function automatic logic [31:0] enc(input int k);
        int a;
        int p;
        logic [31:0] f;
        a = (k < 0) ? -k : k;
        p = 0;
        for (int i = 0; i < 24; i++) if ((a >> i) != 0) p = i;
        f[31]    = (k < 0);
        f[30:23] = 8'(127 - FRAC_W + p);
        f[22:0]  = 23'((a - (1 << p)) << (23 - p));
        return f;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int r;
        r = $urandom_range(0, 9);
        f[31]    = $urandom_range(0, 1);
        f[22:0]  = 23'($urandom);
        if (r == 0)      f[30:23] = 8'd0;
        else if (r == 1) f[30:23] = 8'd255;
        else if (r == 2) f[30:23] = 8'($urandom_range(140, 254));
        else             f[30:23] = 8'($urandom_range(100, 135));
        return f;
    endfunction

    // advance one clock, update the reference model, compare outputs
    task automatic step();
        bit pop_m;
        bit push_m;
        bit cur_acc;
        int cur_d;
        bit cur_s;
        if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
        pop_m   = (mq.size() > 0) && out_ready;
        cur_acc = 1'b0;
        cur_d   = 0;
        cur_s   = 1'b0;
        if (!rst && in_valid) begin
            if (wcnt < WARMUP) wcnt++;
            else begin
                cur_acc = 1'b1;
                ref_conv(in, cur_d, cur_s);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            hv[0] = 0; hv[1] = 0;
            wcnt = 0;
            exp_sat = 0;
            exp_drop = 0;
        end else begin
            push_m   = hv[1];
            exp_drop = push_m && (mq.size() == DEPTH) && !pop_m;
            if (pop_m) void'(mq.pop_front());
            if (push_m && !exp_drop) mq.push_back(hd[1]);
            hv[1] = hv[0]; hd[1] = hd[0]; hs[1] = hs[0];
            hv[0] = cur_acc; hd[0] = cur_d; hs[0] = cur_s;
            exp_sat = hv[1] && hs[1];
        end
        if (drop) drop_cnt++;
        check("level", int'(level), mq.size());
        check("out_valid", int'(out_valid), int'(mq.size() > 0));
        if (mq.size() > 0) check("out_data", int'($signed(out_data)), mq[0]);
        check("sat", int'(sat), int'(exp_sat));
        check("drop", int'(drop), int'(exp_drop));
    endtask

    task automatic conv_case(input string tag, input logic [31:0] f, input int ed, input bit es);
        out_ready = 1'b1;
        in = f;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check({tag, "_sat"}, int'(sat), int'(es));
        check({tag, "_not_early"}, int'(out_valid), 0);
        step();
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_level"}, int'(level), 1);
        check({tag, "_data"}, int'($signed(out_data)), ed);
        step();
        check({tag, "_popped"}, int'(out_valid), 0);
    endtask

    initial begin
        rst = 1'b1;
        in = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        hv[0] = 0; hv[1] = 0;
        hd[0] = 0; hd[1] = 0;
        hs[0] = 0; hs[1] = 0;
        wcnt = 0;
        drop_cnt = 0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_level", int'(level), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_drop", int'(drop), 0);

        // warm-up: first WARMUP samples vanish
        out_ready = 1'b1;
        got.delete();
        for (int k = 1; k <= 6; k++) begin
            in = enc(k);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        check("warm_count", got.size(), 2);
        if (got.size() == 2) begin
            check("warm_first", got[0], 5);
            check("warm_second", got[1], 6);
        end

        // directed conversions and latency
        conv_case("half",     {1'b0, 8'd126, 23'd0}, 16384, 1'b0);
        conv_case("mquarter", {1'b1, 8'd125, 23'd0}, -8192, 1'b0);
        conv_case("denorm",   {1'b0, 8'd0, 23'h12345}, 0, 1'b0);
        conv_case("one",      {1'b0, 8'd127, 23'd0}, 32767, 1'b1);
        conv_case("mone",     {1'b1, 8'd127, 23'd0}, -32768, 1'b0);
        conv_case("inf",      {1'b0, 8'd255, 23'd0}, 32767, 1'b1);
`ifdef FLOAT_PCM_ROUND_EN
        conv_case("rnd_pos",  {1'b0, 8'd111, 23'h400000}, 1, 1'b0);
        conv_case("rnd_neg",  {1'b1, 8'd111, 23'd0}, -1, 1'b0);
`else
        conv_case("rnd_pos",  {1'b0, 8'd111, 23'h400000}, 0, 1'b0);
        conv_case("rnd_neg",  {1'b1, 8'd111, 23'd0}, 0, 1'b0);
`endif

        // FIFO full / drop
        out_ready = 1'b0;
        drop_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            in = enc(k * 10);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("full_level", int'(level), 8);
        check("full_drops", drop_cnt, 2);
        in = enc(999);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pushpop_level", int'(level), 8);
        check("pushpop_drop", int'(drop), 0);
        out_ready = 1'b1;
        repeat (12) step();

        // mid-stream reset
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in = enc(k * 100);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        check("mid_level_before", int'(level), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_level_after", int'(level), 0);
        check("mid_valid_after", int'(out_valid), 0);
        got.delete();
        out_ready = 1'b1;
        for (int k = 1; k <= WARMUP; k++) begin
            in = enc(k);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        check("rewarm_none", got.size(), 0);
        in = enc(77);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("rewarm_one", got.size(), 1);
        if (got.size() == 1) check("rewarm_value", got[0], 77);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            in = rand_float();
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (15) step();
        check("final_empty", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/float_to_pcm.md
# float_to_pcm

Output stage placed directly after the batch filter's final adder. It takes the filter's `floatType` sample stream, discards the warm-up samples produced before the batch pipeline has filled, and converts each remaining sample to saturated signed fixed-point PCM. Converted samples are buffered in a small FIFO behind a ready/valid interface, so a downstream consumer can stall without stalling the free-running filter.

## Interface
- `OUT_W`, 16: output word width, two's complement.
- `FRAC_W`, 15: fractional bits in the output word (LSB weight 2^-FRAC_W).
- `WARMUP`, 64: number of accepted input samples discarded after reset; 0 disables the discard.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `in`  in  `floatType`  filter sample, packed as {sign, exp[`EXP_W`], mant[`MANT_W`]}, exponent bias 2^(`EXP_W`-1)-1.
- `in_valid`  in  1  `in` is a new sample this cycle (one pulse per downsampled clock period).
- `out_data`  out  `OUT_W`  PCM word at the FIFO head.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `sat`  out  1  one-cycle pulse: the sample leaving stage 2 was clipped.
- `drop`  out  1  one-cycle pulse: a converted sample was lost because the FIFO was full.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Warm-up counter counts cycles with `in_valid`=1 and saturates at `WARMUP`.
  - While the counter is below `WARMUP`, the sample is consumed and not forwarded.
  - Sample number `WARMUP`+1 (1-based) is the first one converted.
- Stage 1 registers the following:
  - sign;
  - significand {1, mant}, or 0 when exp==0 (denormals flush to zero);
  - shift amount sh = exp - bias + FRAC_W - MANT_W, signed;
  - an inf flag when exp is all ones.
- Stage 2 computes the magnitude:
  - sh>=0: significand << sh.
  - sh<0: significand >> -sh, with rounding per Configuration.
  - Shifts whose result exceeds OUT_W bits set the overflow condition directly; the datapath is never widened to the full exponent range.
- Stage 2 then applies the sign and saturates:
  - Positive values clip to 2^(OUT_W-1)-1; negative values clip to -2^(OUT_W-1).
  - The exact value -2^(OUT_W-1) is not flagged as saturated.
  - An inf-flagged sample saturates by sign.
  - Saturation raises `sat` for one cycle.
- FIFO push happens when stage 2 holds a valid sample.
  - Push when full with no pop in the same cycle: sample discarded, `drop`=1 for one cycle.
  - Pop happens when `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured at any level, including full (level unchanged).
- `out_data` is a registered FIFO head. It holds stable while `out_valid && !out_ready`.
- Wrap-around: read and write pointers have one extra bit. Full means the indices are equal and the extra bits differ.
- Reset (any cycle, including mid-stream) has the following effects:
  - clears the pipeline valid bits, pointers and warm-up counter;
  - discards FIFO contents;
  - restarts the warm-up discard.
- Reset values: `out_valid`=0, `out_data`=0, `sat`=0, `drop`=0, `level`=0.

## Timing
- Cycle t: `in_valid`=1 with a post-warm-up sample.
  - Edge t+1: stage 1 registered.
  - Edge t+2: stage 2 registered; `sat` asserts in cycle t+2.
  - Edge t+3: FIFO write; `out_valid`=1 in cycle t+3 if the FIFO was empty.
  - `drop` asserts in cycle t+3.
- There is no fall-through path from input to output. Minimum latency is 3 cycles.
- Throughput: one sample per cycle sustained. `in_valid` may be high every cycle, e.g. OSR=1.
- After a pop at edge e, `out_valid` and `out_data` reflect the new head in the cycle following e.
- `level` updates at the same edge as the push or pop.

## Configuration
- `FLOAT_PCM_ROUND_EN` defined:
  - On right shifts, add half an LSB to the magnitude before shifting (round half away from zero), then apply the sign.
  - A round-up that reaches 2^(OUT_W-1) saturates and flags `sat`.
- `FLOAT_PCM_ROUND_EN` undefined: right shifts truncate the magnitude (round toward zero).
- Latency and interface are identical in both builds.

## Test plan
- Conversion values, with defaults and `WARMUP`=0:
  - 0.5 -> 16384;
  - -0.25 -> -8192;
  - exp==0 -> 0;
  - 1.0 -> 32767 with `sat`=1;
  - -1.0 -> -32768 with `sat`=0;
  - inf -> 32767 with `sat`=1.
- Latency: single `in_valid` pulse at cycle 10 -> `out_valid` first high at cycle 13 with `level`=1. With `out_ready`=1, `out_valid` drops at cycle 14.
- Warm-up: `WARMUP`=4, 6 consecutive samples 1..6 (scaled to 2^-15 units) -> exactly two outputs, 5 then 6.
- FIFO boundaries: `out_ready`=0, 10 samples -> `level` saturates at 8 and `drop` pulses twice. Then assert `out_ready` together with a new push at full -> level stays 8, no drop.
- Rounding: input 0.75·2^-15 -> 1 with `FLOAT_PCM_ROUND_EN`, 0 without. Input -0.5·2^-15 -> -1 with, 0 without.
- Mid-stream reset: assert `rst` for 1 cycle with `level`=5 and stage 2 valid -> next cycle `level`=0 and `out_valid`=0. The following `WARMUP` samples produce no output.
